sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of data_in/data_out.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; any integer >= 2, not restricted to powers of 2.
REQ-003 SHALL have parameter AF_TH, default DEPTH-2, almostfull threshold; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AE_TH, default 2, almostempty threshold; legal range 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port: flush  input  1  synchronous clear of contents.
REQ-009 SHALL have port: wr_en  input  1  write request.
REQ-010 SHALL have port: data_in  input  DATA_WIDTH  write data.
REQ-011 SHALL have port: rd_en  input  1  read request.
REQ-012 SHALL have port: data_out  output  DATA_WIDTH  read data.
REQ-013 SHALL have port: wr_ack  output  1  registered; previous-cycle write accepted.
REQ-014 SHALL have port: overflow  output  1  registered; previous-cycle write rejected because full.
REQ-015 SHALL have port: underflow  output  1  registered; previous-cycle read rejected because empty.
REQ-016 SHALL have ports: full, empty, almostfull, almostempty  output  1 each  status flags.
REQ-017 SHALL have port: count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-018 Write accepted iff wr_en=1 and full=0; data_in stored at wr_ptr, and wr_ptr advances.
REQ-019 Read accepted iff rd_en=1 and empty=0; rd_ptr advances.
REQ-020 Pointer wrap: a pointer at DEPTH-1 SHALL advance to 0; no other wrap rule applies.
REQ-021 Simultaneous accepted read and write: both occur, and count is unchanged.
REQ-022 Simultaneous request when empty: only the write is accepted, underflow=1 next cycle, and count goes 0->1.
REQ-023 Simultaneous request when full: only the read is accepted, overflow=1 next cycle, and count goes DEPTH->DEPTH-1.
REQ-024 count: +1 on write only, -1 on read only, unchanged otherwise; never exceeds DEPTH or drops below 0.
REQ-025 Flags are combinational from count: full=(count==DEPTH), empty=(count==0), almostfull=(count>=AF_TH), almostempty=(count<=AE_TH).
REQ-026 wr_ack, overflow and underflow SHALL each be 1 for exactly the cycle after the qualifying event and 0 otherwise.
REQ-027 FWFT=0: on an accepted read, data_out <= mem[rd_ptr] at the same edge (1-cycle latency); otherwise data_out holds.
REQ-028 FWFT=1: data_out = mem[rd_ptr] combinationally when empty=0, and 0 when empty=1; an accepted read exposes the next entry after the edge.
REQ-029 flush=1: wr_ptr, rd_ptr and count go to 0, no write or read is accepted, and wr_ack/overflow/underflow go to 0; data_out holds in FWFT=0.
REQ-030 Memory contents are not cleared by reset or flush; only pointers and count define validity.

Reset
REQ-031 rst_n=0 sampled at a rising edge SHALL set wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0 and underflow=0; this gives empty=1, almostempty=1, full=0 and almostfull=0.
REQ-032 Reset has priority over flush, wr_en and rd_en, and SHALL take effect mid-operation regardless of occupancy; there is no asynchronous effect.

Verification (DATA_WIDTH=16, DEPTH=8, AF_TH=6, AE_TH=2)
REQ-033 Fill then drain, FWFT=0:
- 8 writes 0x0001..0x0008 -> full=1, count=8, wr_ack=1 each cycle.
- 9th write -> overflow=1, count stays 8.
- 8 reads -> data_out 0x0001..0x0008, each one cycle after rd_en.
- Then empty=1.
REQ-034 Underflow: rd_en=1 when empty -> underflow=1 next cycle, count=0, data_out unchanged.
REQ-035 Thresholds: count 0->8 -> almostempty=1 for count<=2, almostfull=1 for count>=6.
REQ-036 Wrap and simultaneity:
- 5 writes, then 5 reads.
- Then 10 cycles of wr_en=rd_en=1 with count=3 -> count stays 3 and data stays in order across the pointer wrap.
- When empty, simultaneous request -> count=1 and underflow=1.
REQ-037 FWFT=1: write 0xABCD into empty FIFO -> data_out=0xABCD the cycle after the write, with no rd_en; read -> data_out=0, empty=1.
REQ-038 Mid-operation clears:
- flush at count=5 -> count=0 next cycle, empty=1.
- rst_n=0 for one edge at count=8 with wr_en=1 -> all outputs at REQ-031 values; no write is accepted.
- Run with DEPTH=5 -> fill/drain order is correct.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, and either registered-read or first-word-fall-through output.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = DEPTH - 2,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       full,
    output logic                       empty,
    output logic                       almostfull,
    output logic                       almostempty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_accept, rd_accept;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        almostfull  = (count_q >= CW'(AF_TH));
        almostempty = (count_q <= CW'(AE_TH));

        wr_accept   = wr_en & ~full & ~flush;
        rd_accept   = rd_en & ~empty & ~flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_accept;
        overflow_d  = wr_en & full & ~flush;
        underflow_d = rd_en & empty & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_accept) rd_ptr_d = next_ptr(rd_ptr_q);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

            always_comb begin
                data_out_d = data_out_q;
                if (rd_accept) data_out_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) data_out_q <= '0;
                else        data_out_q <= data_out_d;
            end

            assign data_out = data_out_q;
        end
    endgenerate

    assign count     = count_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read depth 8, FWFT depth 8,
// and registered-read depth 5 instances driven from shared inputs.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst_n, flush, wr_en, rd_en;
    logic [15:0] data_in;

    logic [15:0] dout0, dout1, dout2;
    logic        wr_ack0, ovf0, udf0, full0, empty0, af0, ae0;
    logic        wr_ack1, ovf1, udf1, full1, empty1, af1, ae1;
    logic        wr_ack2, ovf2, udf2, full2, empty2, af2, ae2;
    logic [3:0]  count0, count1;
    logic [2:0]  count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout0), .wr_ack(wr_ack0), .overflow(ovf0),
        .underflow(udf0), .full(full0), .empty(empty0), .almostfull(af0),
        .almostempty(ae0), .count(count0)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout1), .wr_ack(wr_ack1), .overflow(ovf1),
        .underflow(udf1), .full(full1), .empty(empty1), .almostfull(af1),
        .almostempty(ae1), .count(count1)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(5), .AF_TH(3), .AE_TH(1), .FWFT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout2), .wr_ack(wr_ack2), .overflow(ovf2),
        .underflow(udf2), .full(full2), .empty(empty2), .almostfull(af2),
        .almostempty(ae2), .count(count2)
    );

    typedef struct {
        logic        wr, rd, fl;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [3:0]  flags;   // {full, empty, almostfull, almostempty}
        logic [2:0]  pulses;  // {wr_ack, overflow, underflow}
        logic [15:0] dout;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];

    function automatic logic [3:0] flags_for(input int c);
        return {c == 8, c == 0, c >= 6, c <= 2};
    endfunction

    function automatic void add(input logic w, r, f, input logic [15:0] d,
                                input int c, input logic [2:0] p, input logic [15:0] o);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.din = d;
        v.cnt = 4'(c); v.flags = flags_for(c); v.pulses = p; v.dout = o;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, r, f, input logic [15:0] d);
        wr_en = w; rd_en = r; flush = f; data_in = d;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_in = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_count", 32'(count0), 32'd0);
        chk("reset_flags", 32'({full0, empty0, af0, ae0}), 32'b0101);
        chk("reset_pulses", 32'({wr_ack0, ovf0, udf0}), 32'd0);
        chk("reset_dout", 32'(dout0), 32'd0);
        chk("reset_dout_fwft", 32'(dout1), 32'd0);
        chk("reset_count_d5", 32'(count2), 32'd0);

        // Fill, overflow, drain, underflow, simultaneous-on-empty, flush.
        for (int k = 1; k <= 8; k++) add(1, 0, 0, 16'(k), k, 3'b100, 16'h0);
        add(1, 0, 0, 16'h0009, 8, 3'b010, 16'h0);
        for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'h0, 8 - k, 3'b000, 16'(k));
        add(0, 1, 0, 16'h0, 0, 3'b001, 16'h0008);
        add(0, 0, 0, 16'h0, 0, 3'b000, 16'h0008);
        add(1, 1, 0, 16'h0055, 1, 3'b101, 16'h0008);
        add(1, 0, 0, 16'h0056, 2, 3'b100, 16'h0008);
        add(0, 1, 1, 16'h0, 0, 3'b000, 16'h0008);
        add(0, 1, 0, 16'h0, 0, 3'b001, 16'h0008);

        foreach (vecs[i]) begin
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].din);
            chk($sformatf("vec%0d_count", i), 32'(count0), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_flags", i), 32'({full0, empty0, af0, ae0}), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_pulses", i), 32'({wr_ack0, ovf0, udf0}), 32'(vecs[i].pulses));
            chk($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].dout));
        end

        // Pointer wrap with continuous simultaneous read/write at count 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 16'h0010 + 16'(i));
            exp_q.push_back(16'h0010 + 16'(i));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 16'h0);
            chk("wrap_pre_rd", 32'(dout0), 32'(exp_q.pop_front()));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 16'h0020 + 16'(i));
            exp_q.push_back(16'h0020 + 16'(i));
        end
        chk("wrap_count3", 32'(count0), 32'd3);
        for (int j = 0; j < 10; j++) begin
            cyc(1, 1, 0, 16'h0030 + 16'(j));
            exp_q.push_back(16'h0030 + 16'(j));
            chk("wrap_sim_dout", 32'(dout0), 32'(exp_q.pop_front()));
            chk("wrap_sim_count", 32'(count0), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 16'h0);
            chk("wrap_drain", 32'(dout0), 32'(exp_q.pop_front()));
        end
        chk("wrap_empty", 32'(empty0), 32'd1);
        cyc(1, 1, 0, 16'h0077);
        chk("sim_empty_count", 32'(count0), 32'd1);
        chk("sim_empty_pulses", 32'({wr_ack0, ovf0, udf0}), 32'b101);

        // First-word-fall-through visibility.
        do_reset();
        chk("fwft_empty_dout", 32'(dout1), 32'd0);
        cyc(1, 0, 0, 16'hABCD);
        chk("fwft_dout", 32'(dout1), 32'h0000ABCD);
        chk("fwft_not_empty", 32'(empty1), 32'd0);
        cyc(0, 1, 0, 16'h0);
        chk("fwft_rd_dout", 32'(dout1), 32'd0);
        chk("fwft_rd_empty", 32'(empty1), 32'd1);

        // Flush at count 5, with a concurrent write request.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0080 + 16'(i));
        chk("flush_pre_count", 32'(count0), 32'd5);
        cyc(1, 0, 1, 16'h0099);
        chk("flush_count", 32'(count0), 32'd0);
        chk("flush_empty", 32'(empty0), 32'd1);
        chk("flush_pulses", 32'({wr_ack0, ovf0, udf0}), 32'd0);

        // Reset while full with a write pending.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 16'h0041 + 16'(i));
        cyc(0, 1, 0, 16'h0);
        chk("rst_pre_dout", 32'(dout0), 32'h41);
        cyc(1, 0, 0, 16'h0049);
        chk("rst_pre_count", 32'(count0), 32'd8);
        rst_n = 1'b0; wr_en = 1'b1; data_in = 16'h005A;
        step();
        rst_n = 1'b1;
        chk("rst_mid_count", 32'(count0), 32'd0);
        chk("rst_mid_flags", 32'({full0, empty0, af0, ae0}), 32'b0101);
        chk("rst_mid_pulses", 32'({wr_ack0, ovf0, udf0}), 32'd0);
        chk("rst_mid_dout", 32'(dout0), 32'd0);
        cyc(0, 1, 0, 16'h0);
        chk("rst_no_write", 32'({count0, udf0}), 32'b00001);

        // Non-power-of-two depth.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0061 + 16'(i));
        chk("d5_full", 32'({full2, count2}), 32'b1101);
        cyc(1, 0, 0, 16'h0066);
        chk("d5_overflow", 32'({ovf2, count2}), 32'b1101);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 16'h0);
            chk("d5_drain", 32'(dout2), 32'h61 + 32'(i));
        end
        chk("d5_empty", 32'(empty2), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
